// File: rtl/signed_sat_accumulator_pkg.sv
// ----------------------------------------------------------------------------
// signed_sat_accumulator_pkg
//   Shared types and helpers for the saturating frame accumulator.
//   - state_t : frame FSM states (IDLE after reset, ACC while summing,
//               OUT while the frame result waits for the downstream handshake)
//   - sat_max : largest two's-complement value of a given width
//   - sat_min : smallest two's-complement value of a given width
// ----------------------------------------------------------------------------
package signed_sat_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/signed_sat_accumulator_if.sv
// ----------------------------------------------------------------------------
// signed_sat_accumulator_if
//   Sample input stream and frame result stream of the accumulator.
//   Ports (signals):
//     up_valid   : upstream sample valid            (master -> slave)
//     up_ready   : accumulator can take a sample    (slave  -> master)
//     up_data    : signed sample, WIDTH bits        (master -> slave)
//     down_valid : frame result valid               (slave  -> master)
//     down_ready : downstream accepts the result    (master -> slave)
//     down_data  : saturated signed frame sum       (slave  -> master)
//     down_sat   : a saturation happened this frame (slave  -> master)
//   Modports: master = environment around the block, slave = the accumulator.
// ----------------------------------------------------------------------------
interface signed_sat_accumulator_if #(
    parameter int WIDTH = 4
);
    logic                    up_valid;
    logic                    up_ready;
    logic signed [WIDTH-1:0] up_data;
    logic                    down_valid;
    logic                    down_ready;
    logic signed [WIDTH-1:0] down_data;
    logic                    down_sat;

    modport master (
        output up_valid, up_data, down_ready,
        input  up_ready, down_valid, down_data, down_sat
    );

    modport slave (
        input  up_valid, up_data, down_ready,
        output up_ready, down_valid, down_data, down_sat
    );
endinterface

// File: rtl/signed_sat_accumulator_sat_add_w.sv
// ----------------------------------------------------------------------------
// sat_add_w
//   Combinational WIDTH-bit signed adder with saturation.
//   Ports:
//     a, b     : signed operands
//     sum      : a + b, clamped to the signed range on overflow
//     overflow : the wrapped sum changed sign although both operands agree
// ----------------------------------------------------------------------------
module sat_add_w
    import signed_sat_accumulator_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum,
    output logic                    overflow
);

    localparam int HI_I = sat_max(WIDTH);
    localparam int LO_I = sat_min(WIDTH);
    localparam logic signed [WIDTH-1:0] SAT_HI = HI_I[WIDTH-1:0];
    localparam logic signed [WIDTH-1:0] SAT_LO = LO_I[WIDTH-1:0];

    logic signed [WIDTH-1:0] raw;

    always_comb begin
        raw      = a + b;
        // Same-sign operands with a result of the other sign is the only overflow case.
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
        sum      = raw;
        if (overflow) begin
            sum = a[WIDTH-1] ? SAT_LO : SAT_HI;
        end
    end

endmodule

// File: rtl/signed_sat_accumulator.sv
// ----------------------------------------------------------------------------
// signed_sat_accumulator
//   Sums frames of N_SAMPLES signed samples with per-add saturation and a
//   sticky per-frame saturation flag; presents each frame result on a
//   valid/ready stream with full backpressure.
//   Ports:
//     clk   : clock, rising edge active
//     rst_n : asynchronous reset, active-low
//     bus   : slave side of signed_sat_accumulator_if (up_* sample stream,
//             down_* result stream)
//   All outputs come from registers or from decoding the registered state.
// ----------------------------------------------------------------------------
module signed_sat_accumulator
    import signed_sat_accumulator_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int N_SAMPLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    signed_sat_accumulator_if.slave      bus
);

    localparam int CNT_W = $clog2(N_SAMPLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic                    up_ready_d;
    logic                    down_valid_d;

    logic signed [WIDTH-1:0] acc_p0;
    logic [CNT_W-1:0]        cnt_p0;
    logic                    sticky_p0;

    logic signed [WIDTH-1:0] sum_p0;
    logic                    ovf_p0;
    logic                    sticky_nxt;
    logic                    take;
    logic                    last;
    logic                    drain;

    logic signed [WIDTH-1:0] res_data_p1;
    logic                    res_sat_p1;

    sat_add_w #(
        .WIDTH (WIDTH)
    ) u_sat_add (
        .a        (acc_p0),
        .b        (bus.up_data),
        .sum      (sum_p0),
        .overflow (ovf_p0)
    );

    // up_ready is exactly "state is ACC", so a transfer is ACC & up_valid.
    assign take       = (state_q == ACC) && bus.up_valid;
    assign last       = (cnt_p0 == LAST_CNT);
    assign drain      = (state_q == OUT) && bus.down_ready;
    assign sticky_nxt = sticky_p0 | ovf_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        up_ready_d   = 1'b0;
        down_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = ACC;
            end
            ACC: begin
                up_ready_d = 1'b1;
                if (take && last) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                down_valid_d = 1'b1;
                if (drain) begin
                    state_d = ACC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---- stage p0: running sum, sample count and sticky saturation flag ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p0    <= '0;
            cnt_p0    <= '0;
            sticky_p0 <= 1'b0;
        end else if (take) begin
            acc_p0    <= sum_p0;
            cnt_p0    <= cnt_p0 + CNT_W'(1);
            sticky_p0 <= sticky_nxt;
        end else if (drain) begin
            acc_p0    <= '0;
            cnt_p0    <= '0;
            sticky_p0 <= 1'b0;
        end
    end

    // ---- stage p1: frame result, held until the downstream handshake ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_p1 <= '0;
            res_sat_p1  <= 1'b0;
        end else if (take && last) begin
            res_data_p1 <= sum_p0;
            res_sat_p1  <= sticky_nxt;
        end
    end

    assign bus.up_ready   = up_ready_d;
    assign bus.down_valid = down_valid_d;
    assign bus.down_data  = res_data_p1;
    assign bus.down_sat   = res_sat_p1;

endmodule

// File: tb/tb_signed_sat_accumulator.sv
module tb_signed_sat_accumulator;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int HI = (1 << (W - 1)) - 1;
    localparam int LO = -(1 << (W - 1));

    typedef struct {
        int data;
        bit sat;
    } exp_t;

    logic clk;
    logic rst_n;

    signed_sat_accumulator_if #(.WIDTH(W)) bus ();

    signed_sat_accumulator #(
        .WIDTH     (W),
        .N_SAMPLES (N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   mdl_acc = 0;
    int   mdl_cnt = 0;
    bit   mdl_sat = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mdl_acc = 0;
        mdl_cnt = 0;
        mdl_sat = 1'b0;
    endtask

    // Called at a falling edge while in ACC; the sample transfers on the next rising edge.
    task automatic send(input int x);
        check("up_ready_acc", int'(bus.up_ready), 1);
        bus.up_valid = 1'b1;
        bus.up_data  = W'(x);
        @(negedge clk);
        bus.up_valid = 1'b0;
        mdl_acc = mdl_acc + x;
        if (mdl_acc > HI) begin
            mdl_acc = HI;
            mdl_sat = 1'b1;
        end else if (mdl_acc < LO) begin
            mdl_acc = LO;
            mdl_sat = 1'b1;
        end
        mdl_cnt++;
        if (mdl_cnt == N) begin
            sb.push_back('{data: mdl_acc, sat: mdl_sat});
            model_clear();
        end
    endtask

    task automatic bubble();
        bus.up_valid = 1'b0;
        @(negedge clk);
    endtask

    // Waits (bounded) for down_valid, compares against the scoreboard head,
    // completes the handshake and checks down_valid drops for the next cycle.
    task automatic take_result(input string tag, input bit immediate);
        int   waited = 0;
        exp_t e;
        while (!bus.down_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_down_valid"}, int'(bus.down_valid), 1);
        if (immediate) check({tag, "_latency"}, waited, 0);
        check({tag, "_sb_nonempty"}, int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_down_data"}, int'(bus.down_data), e.data);
            check({tag, "_down_sat"}, int'(bus.down_sat), int'(e.sat));
        end
        bus.down_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_drop"}, int'(bus.down_valid), 0);
        check({tag, "_up_ready_back"}, int'(bus.up_ready), 1);
    endtask

    initial begin
        int   hold_data;
        int   hold_sat;
        bus.up_valid   = 1'b0;
        bus.up_data    = '0;
        bus.down_ready = 1'b0;
        rst_n          = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_up_ready", int'(bus.up_ready), 0);
        check("rst_down_valid", int'(bus.down_valid), 0);
        check("rst_down_data", int'(bus.down_data), 0);
        check("rst_down_sat", int'(bus.down_sat), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("idle_up_ready", int'(bus.up_ready), 0);
        @(negedge clk);
        check("acc_up_ready", int'(bus.up_ready), 1);

        // Plain frame, downstream always ready.
        bus.down_ready = 1'b1;
        send(1); send(2); send(-1); send(3);
        take_result("t1", 1'b1);

        // Positive saturation mid-frame, then recovery from the clamp.
        send(7); send(4); send(-2); send(-3);
        take_result("t2", 1'b1);

        // Negative saturation, then a clean frame shows the flag cleared.
        send(-8); send(-1); send(0); send(0);
        take_result("t3a", 1'b1);
        send(1); send(1); send(1); send(1);
        take_result("t3b", 1'b1);

        // Backpressure: result held, sample input blocked.
        bus.down_ready = 1'b0;
        send(3); send(-2); send(1); send(1);
        check("t4_down_valid", int'(bus.down_valid), 1);
        hold_data = int'(bus.down_data);
        hold_sat  = int'(bus.down_sat);
        bus.up_valid = 1'b1;
        bus.up_data  = W'(5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_up_ready_blocked", int'(bus.up_ready), 0);
            check("t4_valid_held", int'(bus.down_valid), 1);
            check("t4_data_stable", int'(bus.down_data), hold_data);
            check("t4_sat_stable", int'(bus.down_sat), hold_sat);
        end
        bus.up_valid = 1'b0;
        take_result("t4", 1'b0);
        send(0); send(0); send(0); send(0);
        take_result("t4b", 1'b1);

        // Bubbles between samples are not counted.
        send(2); bubble(); bubble(); send(2); bubble(); send(2); send(2);
        take_result("t5", 1'b1);

        // Asynchronous reset in the middle of a frame.
        send(3); send(3);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check("t6_rst_up_ready", int'(bus.up_ready), 0);
        check("t6_rst_down_valid", int'(bus.down_valid), 0);
        check("t6_rst_down_data", int'(bus.down_data), 0);
        check("t6_rst_down_sat", int'(bus.down_sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_idle_up_ready", int'(bus.up_ready), 0);
        @(negedge clk);
        check("t6_acc_up_ready", int'(bus.up_ready), 1);
        send(1); send(0); send(0); send(0);
        take_result("t6", 1'b1);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
